// File: rtl/tpumac_cell_p.sv
// tpumac_cell_p: parametrised systolic multiply-accumulate processing element.
//   Forwards A east and B south after one cycle and accumulates signed A*B into
//   a BITS_C accumulator with selectable saturate/wrap and a sticky overflow flag.
//   Optional multiplier pipeline register (MUL_PIPE=1) adds one cycle of latency.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   en             advance enable (forwarding, product stage, accumulate)
//   WrEn           parallel load of Cin into the accumulator, clears ovf
//   sat            1: saturate on overflow, 0: two's-complement wrap
//   Ain, Bin       signed operands (BITS_AB)
//   Cin            signed accumulator load value (BITS_C)
//   Aout, Bout     registered operands to east/south neighbours
//   Cout           accumulator value
//   ovf            sticky overflow flag
module tpumac_cell_p #(
  parameter int unsigned BITS_AB  = 8,
  parameter int unsigned BITS_C   = 16,
  parameter int unsigned MUL_PIPE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               WrEn,
  input  logic               sat,
  input  logic [BITS_AB-1:0] Ain,
  input  logic [BITS_AB-1:0] Bin,
  input  logic [BITS_C-1:0]  Cin,
  output logic [BITS_AB-1:0] Aout,
  output logic [BITS_AB-1:0] Bout,
  output logic [BITS_C-1:0]  Cout,
  output logic               ovf
);

  localparam int unsigned W_P = 2 * BITS_AB;
  localparam int unsigned W_S = BITS_C + 1;
  localparam logic [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  // The full product must fit in the accumulator width.
  if (BITS_C < W_P) begin : g_width_check
    $error("tpumac_cell_p: BITS_C must be >= 2*BITS_AB");
  end

  logic signed [BITS_C-1:0] acc;
  logic signed [W_P-1:0]    prod_c;
  logic signed [W_P-1:0]    addend_c;
  logic                     add_en_c;
  logic signed [W_S-1:0]    sum_c;
  logic                     sum_ovf_c;
  logic [BITS_C-1:0]        acc_next_c;

  // Full-width signed product of the current operands.
  assign prod_c = W_P'($signed(Ain)) * W_P'($signed(Bin));

  if (MUL_PIPE != 0) begin : g_pipe
    logic signed [W_P-1:0] preg;
    logic                  pvalid;

    // Product register; a load discards whatever product is in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        preg   <= '0;
        pvalid <= 1'b0;
      end else begin
        if (en) preg <= prod_c;
        if (WrEn)    pvalid <= 1'b0;
        else if (en) pvalid <= 1'b1;
      end
    end

    assign addend_c = preg;
    assign add_en_c = en & pvalid;
  end else begin : g_nopipe
    assign addend_c = prod_c;
    assign add_en_c = en;
  end

  // One extra bit of headroom: overflow shows as disagreement of the top two bits.
  assign sum_c     = W_S'(acc) + W_S'(addend_c);
  assign sum_ovf_c = sum_c[W_S-1] ^ sum_c[W_S-2];

  always_comb begin
    acc_next_c = sum_c[BITS_C-1:0];
    if (sum_ovf_c && sat) begin
      acc_next_c = sum_c[W_S-1] ? C_MIN : C_MAX;
    end
  end

  // Operand forwarding, accumulator and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      Aout <= '0;
      Bout <= '0;
      acc  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (en) begin
        Aout <= Ain;
        Bout <= Bin;
      end
      if (WrEn) begin
        acc <= $signed(Cin);
        ovf <= 1'b0;
      end else if (add_en_c) begin
        acc <= $signed(acc_next_c);
        if (sum_ovf_c) ovf <= 1'b1;
      end
    end
  end

  assign Cout = acc;

endmodule

// File: tb/tb_tpumac_cell_p.sv
// Bench for tpumac_cell_p: both MUL_PIPE variants driven from shared stimulus and
// compared every cycle against an integer reference model of the MAC rules.
module tb_tpumac_cell_p;

  logic clk;
  logic rst;
  logic en;
  logic WrEn;
  logic sat;
  logic signed [7:0]  Ain;
  logic signed [7:0]  Bin;
  logic signed [15:0] Cin;

  logic signed [7:0]  aout0, bout0, aout1, bout1;
  logic signed [15:0] cout0, cout1;
  logic               ovf0, ovf1;

  int n_chk;
  int n_pass;

  // Reference state per variant (index = MUL_PIPE)
  int m_acc[2];
  int m_prg[2];
  bit m_ovf[2];
  bit m_pv[2];
  int m_a[2];
  int m_b[2];

  tpumac_cell_p #(.BITS_AB(8), .BITS_C(16), .MUL_PIPE(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .sat(sat),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(aout0), .Bout(bout0), .Cout(cout0), .ovf(ovf0)
  );

  tpumac_cell_p #(.BITS_AB(8), .BITS_C(16), .MUL_PIPE(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .sat(sat),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(aout1), .Bout(bout1), .Cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply the MAC rules to the reference for one rising edge.
  task automatic model_edge(input bit r, input bit e, input bit w, input bit s,
                            input int a, input int b, input int c);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_acc[k] = 0; m_prg[k] = 0; m_ovf[k] = 0; m_pv[k] = 0;
        m_a[k] = 0; m_b[k] = 0;
      end else begin
        int p;
        int addp;
        int sum;
        bit adde;
        p    = a * b;
        addp = (k == 1) ? m_prg[k] : p;
        adde = e && ((k == 0) || m_pv[k]);
        if (w) begin
          m_acc[k] = c;
          m_ovf[k] = 0;
        end else if (adde) begin
          sum = m_acc[k] + addp;
          if (sum > 32767 || sum < -32768) begin
            m_ovf[k] = 1;
            if (s) m_acc[k] = (sum > 0) ? 32767 : -32768;
            else   m_acc[k] = (sum > 32767) ? sum - 65536 : sum + 65536;
          end else begin
            m_acc[k] = sum;
          end
        end
        if (k == 1) begin
          if (e) m_prg[k] = p;
          if (w) m_pv[k] = 0;
          else if (e) m_pv[k] = 1;
        end
        if (e) begin
          m_a[k] = a;
          m_b[k] = b;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("cout0", int'(cout0), m_acc[0]);
    chk("aout0", int'(aout0), m_a[0]);
    chk("bout0", int'(bout0), m_b[0]);
    chk("ovf0",  int'(ovf0),  int'(m_ovf[0]));
    chk("cout1", int'(cout1), m_acc[1]);
    chk("aout1", int'(aout1), m_a[1]);
    chk("bout1", int'(bout1), m_b[1]);
    chk("ovf1",  int'(ovf1),  int'(m_ovf[1]));
  endtask

  // Drive one cycle, advance the model across the edge, then check #1 later.
  task automatic step(input bit r, input bit e, input bit w, input bit s,
                      input int a, input int b, input int c);
    rst  = r;
    en   = e;
    WrEn = w;
    sat  = s;
    Ain  = 8'(a);
    Bin  = 8'(b);
    Cin  = 16'(c);
    @(posedge clk);
    model_edge(r, e, w, s, a, b, c);
    #1;
    compare_all();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_prg[k] = 0; m_ovf[k] = 0; m_pv[k] = 0;
      m_a[k] = 0; m_b[k] = 0;
    end
    rst = 1'b1; en = 1'b0; WrEn = 1'b0; sat = 1'b0;
    Ain = '0; Bin = '0; Cin = '0;

    // Reset state
    step(1, 1, 1, 0, 5, 5, 77);
    chk("rst_cout", int'(cout0), 0);
    chk("rst_aout", int'(aout0), 0);
    chk("rst_ovf",  int'(ovf1),  0);

    // Load then one MAC, no product pipeline
    step(0, 0, 1, 0, 0, 0, 100);
    chk("t1_load", int'(cout0), 100);
    step(0, 1, 0, 0, 3, -4, 0);
    chk("t1_mac",  int'(cout0), 88);
    chk("t1_aout", int'(aout0), 3);
    chk("t1_bout", int'(bout0), -4);

    // Positive saturation, ovf sticky
    step(0, 0, 1, 1, 0, 0, 32000);
    step(0, 1, 0, 1, 100, 100, 0);
    chk("t2_sat",   int'(cout0), 32767);
    chk("t2_ovf",   int'(ovf0),  1);
    step(0, 1, 0, 1, -1, 1, 0);
    chk("t2_after", int'(cout0), 32766);
    chk("t2_stick", int'(ovf0),  1);

    // Wrap, then reload clears ovf
    step(0, 0, 1, 0, 0, 0, 32000);
    step(0, 1, 0, 0, 100, 100, 0);
    chk("t3_wrap", int'(cout0), -23536);
    chk("t3_ovf",  int'(ovf0),  1);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t3_load", int'(cout0), 0);
    chk("t3_clr",  int'(ovf0),  0);

    // Negative saturation
    step(0, 0, 1, 1, 0, 0, -32768);
    step(0, 1, 0, 1, -1, 1, 0);
    chk("t4_neg",   int'(cout0), -32768);
    chk("t4_ovf",   int'(ovf0),  1);
    step(0, 1, 0, 1, -128, -128, 0);
    chk("t4_stick", int'(ovf0),  1);

    // Product pipeline: two-edge latency, en gap holds, load drops in-flight product
    step(0, 0, 1, 0, 0, 0, 0);
    chk("t5_load", int'(cout1), 0);
    step(0, 1, 0, 0, 2, 5, 0);
    chk("t5_c0",   int'(cout1), 0);
    step(0, 1, 0, 0, 3, 3, 0);
    chk("t5_c10",  int'(cout1), 10);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t5_c19",  int'(cout1), 19);
    step(0, 0, 0, 0, 7, 7, 0);
    chk("t5_hold", int'(cout1), 19);
    chk("t5_ahld", int'(aout1), 0);
    step(0, 1, 0, 0, 4, 4, 0);
    step(0, 1, 1, 0, 1, 1, 5);
    chk("t5_ld5",  int'(cout1), 5);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t5_drop", int'(cout1), 5);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("t5_drop2", int'(cout1), 5);

    // Random soak with a mid-run reset
    for (int ld = 0; ld < 100; ld++) begin
      step(0, $urandom_range(1) != 0, 1, $urandom_range(1) != 0,
           int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
           int'($urandom_range(65535)) - 32768);
      for (int i = 0; i < 100; i++) begin
        if (ld == 50 && i == 40) begin
          step(1, 1, $urandom_range(1) != 0, 1, 17, -9, 1234);
          chk("soak_rst_c0", int'(cout0), 0);
          chk("soak_rst_c1", int'(cout1), 0);
          chk("soak_rst_a1", int'(aout1), 0);
          chk("soak_rst_o0", int'(ovf0),  0);
        end else begin
          step(0, $urandom_range(3) != 0, $urandom_range(49) == 0,
               $urandom_range(1) != 0,
               int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
               int'($urandom_range(65535)) - 32768);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
